// File: rtl/axilwb_bridge.sv
// rtl/axilwb_bridge.sv - AXI4-lite slave to pipelined Wishbone master bridge with read/write arbitration
//
// Purpose: accepts AXI4-lite reads and writes on one slave port and turns each into a single
// pipelined Wishbone transaction. Only one transaction is in flight at a time. Contested requests
// are granted round-robin. A stuck slave is aborted by a timeout, which returns DECERR.
//
// Ports:
//   i_clk, i_axi_reset_n                     clock and asynchronous active-low reset
//   i_axi_aw*/o_axi_awready, i_axi_w*/o_axi_wready   write address and data, accepted together
//   o_axi_bvalid/i_axi_bready/o_axi_bresp    write response
//   i_axi_ar*/o_axi_arready                  read address
//   o_axi_rvalid/i_axi_rready/o_axi_rdata/o_axi_rresp   read response
//   o_wb_cyc/stb/we/addr/data/sel            Wishbone request (word address)
//   i_wb_stall/ack/err/data                  Wishbone slave status and read data
module axilwb_bridge #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGTIMEOUT        = 8,
    parameter bit OPT_READONLY     = 1'b0,
    parameter bit OPT_WRITEONLY    = 1'b0,
    localparam int DW      = C_AXI_DATA_WIDTH,
    localparam int AW      = C_AXI_ADDR_WIDTH,
    localparam int SW      = DW / 8,
    localparam int ADDRLSB = $clog2(DW / 8),
    localparam int WBAW    = AW - ADDRLSB
) (
    input  logic            i_clk,
    input  logic            i_axi_reset_n,
    // write address / data / response
    input  logic            i_axi_awvalid,
    output logic            o_axi_awready,
    input  logic [AW-1:0]   i_axi_awaddr,
    input  logic [2:0]      i_axi_awprot,
    input  logic            i_axi_wvalid,
    output logic            o_axi_wready,
    input  logic [DW-1:0]   i_axi_wdata,
    input  logic [SW-1:0]   i_axi_wstrb,
    output logic            o_axi_bvalid,
    input  logic            i_axi_bready,
    output logic [1:0]      o_axi_bresp,
    // read address / response
    input  logic            i_axi_arvalid,
    output logic            o_axi_arready,
    input  logic [AW-1:0]   i_axi_araddr,
    input  logic [2:0]      i_axi_arprot,
    output logic            o_axi_rvalid,
    input  logic            i_axi_rready,
    output logic [DW-1:0]   o_axi_rdata,
    output logic [1:0]      o_axi_rresp,
    // wishbone master
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [WBAW-1:0] o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [SW-1:0]   o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The timer counts cycles spent in BUS/WAIT starting from 0; the abort is taken in the
    // cycle where it reads 2^LGTIMEOUT-2, so cyc is high for exactly 2^LGTIMEOUT-1 cycles.
    localparam int TW   = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;
    localparam int TLIM = (LGTIMEOUT > 0) ? (2 ** LGTIMEOUT) - 2 : 0;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TLIM);

    state_t        state, state_d;
    logic          is_write;
    logic          last_grant_write;
    logic [TW-1:0] timer;
    logic [1:0]    resp;
    logic [DW-1:0] rdata_q;

    logic write_req, read_req;
    logic grant_write, grant_read;
    logic on_bus, timed_out, resp_ready;

    // Requests are masked during reset so no ready can be presented while held in reset.
    assign write_req  = i_axi_reset_n && i_axi_awvalid && i_axi_wvalid;
    assign read_req   = i_axi_reset_n && i_axi_arvalid;
    assign on_bus     = (state == S_BUS) || (state == S_WAIT);
    assign timed_out  = (LGTIMEOUT > 0) && (timer == TIMER_LAST);
    assign resp_ready = is_write ? i_axi_bready : i_axi_rready;

    always_comb begin
        state_d     = state;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        case (state)
            S_IDLE: begin
                if (write_req && read_req) begin
                    grant_read  = last_grant_write;
                    grant_write = !last_grant_write;
                end else begin
                    grant_write = write_req;
                    grant_read  = read_req;
                end
                // Disabled directions are accepted but never reach the bus.
                if (grant_write) begin
                    state_d = OPT_READONLY ? S_RESP : S_BUS;
                end else if (grant_read) begin
                    state_d = OPT_WRITEONLY ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (i_wb_ack || i_wb_err || timed_out) begin
                    state_d = S_RESP;
                end else if (!i_wb_stall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_wb_ack || i_wb_err || timed_out) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            state            <= S_IDLE;
            is_write         <= 1'b0;
            last_grant_write <= 1'b1;
            timer            <= '0;
            resp             <= RESP_OKAY;
            rdata_q          <= '0;
            o_wb_we          <= 1'b0;
            o_wb_addr        <= '0;
            o_wb_data        <= '0;
            o_wb_sel         <= '0;
        end else begin
            state <= state_d;
            if (grant_write) begin
                is_write         <= 1'b1;
                last_grant_write <= 1'b1;
                timer            <= '0;
                o_wb_we          <= !OPT_READONLY;
                o_wb_addr        <= i_axi_awaddr[AW-1:ADDRLSB];
                o_wb_data        <= i_axi_wdata;
                o_wb_sel         <= i_axi_wstrb;
                if (OPT_READONLY) begin
                    resp <= RESP_DECERR;
                end
            end else if (grant_read) begin
                is_write         <= 1'b0;
                last_grant_write <= 1'b0;
                timer            <= '0;
                o_wb_we          <= 1'b0;
                o_wb_addr        <= i_axi_araddr[AW-1:ADDRLSB];
                o_wb_sel         <= '1;
                if (OPT_WRITEONLY) begin
                    resp    <= RESP_DECERR;
                    rdata_q <= '0;
                end
            end else if (on_bus) begin
                timer <= timer + TW'(1);
                // err takes priority over a simultaneous ack
                if (i_wb_err) begin
                    resp    <= RESP_SLVERR;
                    rdata_q <= '0;
                end else if (i_wb_ack) begin
                    resp <= RESP_OKAY;
                    if (!is_write) begin
                        rdata_q <= i_wb_data;
                    end
                end else if (timed_out) begin
                    resp    <= RESP_DECERR;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign o_axi_awready = grant_write;
    assign o_axi_wready  = grant_write;
    assign o_axi_arready = grant_read;

    // Response fields only change on entry to RESP, so they hold while valid && !ready.
    assign o_axi_bvalid = (state == S_RESP) && is_write;
    assign o_axi_rvalid = (state == S_RESP) && !is_write;
    assign o_axi_bresp  = resp;
    assign o_axi_rresp  = resp;
    assign o_axi_rdata  = rdata_q;

    assign o_wb_cyc = on_bus;
    assign o_wb_stb = (state == S_BUS);

    logic unused_inputs;
    assign unused_inputs = ^{i_axi_awprot, i_axi_arprot, i_axi_awaddr, i_axi_araddr};

endmodule

// File: tb/tb_axilwb_bridge.sv
// tb/tb_axilwb_bridge.sv - scoreboard testbench for axilwb_bridge
module tb_axilwb_bridge;

    localparam int DW   = 32;
    localparam int AW   = 28;
    localparam int WBAW = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic            awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
    logic [AW-1:0]   awaddr = 0, araddr = 0;
    logic [2:0]      awprot = 0, arprot = 0;
    logic [DW-1:0]   wdata = 0;
    logic [3:0]      wstrb = 0;
    logic            awready, wready, arready, bvalid, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;
    logic            wb_cyc, wb_stb, wb_we;
    logic [WBAW-1:0] wb_addr;
    logic [DW-1:0]   wb_wdata;
    logic [3:0]      wb_sel;
    logic            wb_stall = 0, wb_ack = 0, wb_err = 0;
    logic [DW-1:0]   wb_rdata = 0;

    axilwb_bridge #(
        .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .LGTIMEOUT(4),
        .OPT_READONLY(1'b0), .OPT_WRITEONLY(1'b0)
    ) dut (
        .i_clk(clk), .i_axi_reset_n(rst_n),
        .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr), .i_axi_awprot(awprot),
        .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
        .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
        .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_araddr(araddr), .i_axi_arprot(arprot),
        .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rdata(rdata), .o_axi_rresp(rresp),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
    );

    typedef struct packed { logic is_wr; logic [1:0] resp; logic [31:0] data; } rexp_t;
    typedef struct packed { logic we; logic [25:0] addr; logic [3:0] sel; logic [31:0] data; } wexp_t;
    rexp_t resp_q[$];
    wexp_t wb_q[$];

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // response monitor
    rexp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (resp_q.size() == 0) check("unexpected_b", 1, 0);
                else begin
                    e = resp_q.pop_front();
                    check("b_is_write", 1, 64'(e.is_wr));
                    check("bresp", bresp, e.resp);
                end
            end
            if (rvalid && rready) begin
                if (resp_q.size() == 0) check("unexpected_r", 1, 0);
                else begin
                    e = resp_q.pop_front();
                    check("r_is_read", 0, 64'(e.is_wr));
                    check("rresp", rresp, e.resp);
                    check("rdata", rdata, e.data);
                end
            end
        end
    end

    // wishbone slave model with request scoreboard
    int sl_stall = 0;
    bit sl_err = 0, sl_noack = 0;
    logic [31:0] sl_data = 0;
    int stall_left = 0, stb_cycles = 0, cyc_cycles = 0;
    bit pend = 0;
    wexp_t w;
    always @(negedge clk) begin
        wb_ack = 0;
        wb_err = 0;
        wb_rdata = 0;
        if (!rst_n) begin
            pend = 0;
            wb_stall = 0;
            stall_left = sl_stall;
        end else begin
            if (pend) begin
                pend = 0;
                if (!sl_noack && wb_cyc) begin
                    wb_ack = 1;
                    wb_err = sl_err;
                    wb_rdata = sl_data;
                end
            end
            if (wb_cyc) cyc_cycles++;
            if (wb_cyc && wb_stb) begin
                stb_cycles++;
                if (stall_left > 0) begin
                    wb_stall = 1;
                    stall_left--;
                end else begin
                    wb_stall = 0;
                    pend = 1;
                    if (wb_q.size() == 0) check("unexpected_stb", 1, 0);
                    else begin
                        w = wb_q.pop_front();
                        check("wb_we", wb_we, w.we);
                        check("wb_addr", wb_addr, w.addr);
                        check("wb_sel", wb_sel, w.sel);
                        if (w.we) check("wb_data", wb_wdata, w.data);
                    end
                end
            end else begin
                wb_stall = 0;
                stall_left = sl_stall;
            end
        end
    end

    task automatic issue_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] er);
        bit got = 0;
        wb_q.push_back({1'b1, a[27:2], s, d});
        resp_q.push_back({1'b1, er, 32'h0});
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (awready && wready) got = 1;
        end
        check("aw_grant", 64'(got), 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic issue_read(input logic [27:0] a, input logic [1:0] er, input logic [31:0] ed);
        bit got = 0;
        wb_q.push_back({1'b0, a[27:2], 4'hF, 32'h0});
        resp_q.push_back({1'b0, er, ed});
        araddr = a; arvalid = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (arready) got = 1;
        end
        check("ar_grant", 64'(got), 1);
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && resp_q.size() != 0; i++) @(negedge clk);
        check("resp_drain", resp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order;
        int nrd, nwr, ng, n;
        bit got;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk); #1 rst_n = 1;

        // contested requests alternate R,W,R,W from reset
        sl_data = 32'hA5A5_0001;
        araddr = 28'h100; awaddr = 28'h200; wdata = 32'h1111_2222; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        order = 0; nrd = 0; nwr = 0; ng = 0;
        for (int c = 0; c < 200 && (nrd < 2 || nwr < 2); c++) begin
            @(negedge clk);
            if (arready) begin
                wb_q.push_back({1'b0, araddr[27:2], 4'hF, 32'h0});
                resp_q.push_back({1'b0, 2'b00, sl_data});
                order = {order[2:0], 1'b0}; nrd++; ng++;
            end
            if (awready) begin
                wb_q.push_back({1'b1, awaddr[27:2], wstrb, wdata});
                resp_q.push_back({1'b1, 2'b00, 32'h0});
                order = {order[2:0], 1'b1}; nwr++; ng++;
            end
            @(posedge clk); #1;
            if (nrd == 2) arvalid = 0;
            if (nwr == 2) begin awvalid = 0; wvalid = 0; end
        end
        check("grant_order", order, 4'b0101);
        check("grant_count", ng, 4);
        wait_idle();

        // minimum-latency write
        stb_cycles = 0;
        issue_write(28'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
        n = 0;
        for (int i = 0; i < 20 && !bvalid; i++) begin @(negedge clk); n++; end
        check("write_latency", n, 3);
        check("write_stb_cycles", stb_cycles, 1);
        wait_idle();

        // stalled read
        sl_stall = 3; sl_data = 32'h1234_5678; stb_cycles = 0;
        issue_read(28'h20, 2'b00, 32'h1234_5678);
        wait_idle();
        check("read_stb_cycles", stb_cycles, 4);
        sl_stall = 0;

        // err with ack on a write, then a timed-out read
        sl_err = 1;
        issue_write(28'h40, 32'h0BAD_F00D, 4'h3, 2'b10);
        wait_idle();
        sl_err = 0;
        sl_noack = 1; cyc_cycles = 0;
        issue_read(28'h44, 2'b11, 32'h0);
        wait_idle();
        check("timeout_cyc_cycles", cyc_cycles, 15);
        sl_noack = 0;

        // back-pressured read response
        rready = 0; sl_data = 32'hCAFE_0005;
        issue_read(28'h80, 2'b00, 32'hCAFE_0005);
        for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
        @(posedge clk); #1;
        wb_q.push_back({1'b0, 26'h21, 4'hF, 32'h0});
        resp_q.push_back({1'b0, 2'b00, 32'h5A5A_0006});
        araddr = 28'h84; arvalid = 1;
        repeat (5) begin
            @(negedge clk);
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, 32'hCAFE_0005);
            check("hold_rresp", rresp, 0);
            check("hold_arready", arready, 0);
        end
        @(posedge clk); #1 rready = 1; sl_data = 32'h5A5A_0006;
        @(negedge clk);
        check("bubble_arready", arready, 0);
        got = 0; n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); n++;
            if (arready) got = 1;
        end
        check("regrant_delay", n, 1);
        @(posedge clk); #1 arvalid = 0;
        wait_idle();

        // reset while waiting for an ack
        sl_noack = 1;
        wb_q.push_back({1'b0, 26'h24, 4'hF, 32'h0});
        araddr = 28'h90; arvalid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (arready) got = 1; end
        @(posedge clk); #1 arvalid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (wb_cyc && !wb_stb) got = 1; end
        check("reached_wait", 64'(got), 1);
        #2 rst_n = 0;
        #1;
        check("arst_cyc", wb_cyc, 0);
        check("arst_stb", wb_stb, 0);
        check("arst_bvalid", bvalid, 0);
        check("arst_rvalid", rvalid, 0);
        wb_q.delete();
        sl_noack = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        sl_data = 32'h600D_600D;
        issue_read(28'hA0, 2'b00, 32'h600D_600D);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
